// File: rtl/cal_trg_seq_if.sv
// Command, configuration and trigger-output bundle of the calibration trigger sequencer.
// The master drives commands and settings. The slave (the sequencer) drives the pulses and status.
interface cal_trg_seq_if;
    logic       CMD_INJ;
    logic       CMD_PLS;
    logic       CMD_PED;
    logic       ABORT;
    logic [4:0] INJ_DLY;
    logic [4:0] EXT_DLY;
    logic [3:0] LCT_DLY;
    logic [4:0] L1A_DLY;
    logic [7:0] BURST_LEN;
    logic [7:0] BURST_GAP;
    logic       INJECT;
    logic       PULSE;
    logic       PEDESTAL;
    logic       CAL_LCT;
    logic       CAL_GTRG;
    logic       BUSY;
    logic       DONE;
    logic       OVERRUN;
    logic [7:0] SEQ_CNT;

    modport master (
        output CMD_INJ, CMD_PLS, CMD_PED, ABORT,
        output INJ_DLY, EXT_DLY, LCT_DLY, L1A_DLY, BURST_LEN, BURST_GAP,
        input  INJECT, PULSE, PEDESTAL, CAL_LCT, CAL_GTRG, BUSY, DONE, OVERRUN, SEQ_CNT
    );

    modport slave (
        input  CMD_INJ, CMD_PLS, CMD_PED, ABORT,
        input  INJ_DLY, EXT_DLY, LCT_DLY, L1A_DLY, BURST_LEN, BURST_GAP,
        output INJECT, PULSE, PEDESTAL, CAL_LCT, CAL_GTRG, BUSY, DONE, OVERRUN, SEQ_CNT
    );
endinterface

// File: rtl/cal_trg_seq.sv
// Calibration trigger sequencer. It issues one stimulus (inject, pulse or pedestal), then CAL_LCT, then CAL_GTRG.
// The sequence can repeat as a burst. All timing settings are captured when a command is accepted.
module cal_trg_seq #(
    parameter bit SIM = 1'b0
) (
    input  logic          CLKCMS,
    input  logic          RST,
    cal_trg_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STIM_WAIT = 3'd1,
        LCT_WAIT  = 3'd2,
        L1A_WAIT  = 3'd3,
        GAP       = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] dly_q, dly_d;
    logic [7:0] gap_q, gap_d;
    logic [4:0] stim_dly_q, stim_dly_d;
    logic [3:0] lct_q, lct_d;
    logic [4:0] l1a_q, l1a_d;
    logic [7:0] rep_q, rep_d;
    logic [7:0] gap_len_q, gap_len_d;
    logic [7:0] seq_q, seq_d;
    logic [2:0] typ_q, typ_d;
    logic       done_q, done_d;
    logic       ovr_q, ovr_d;

    logic       cmd_any;
    logic       dly_zero;
    logic       stim_fire;
    logic       lct_fire;
    logic       gtrg_fire;
    logic       busy;
    logic [2:0] stim_vec;

    assign cmd_any  = bus.CMD_INJ | bus.CMD_PLS | bus.CMD_PED;
    assign dly_zero = (dly_q == 5'd0);

    // State register
    always_ff @(posedge CLKCMS) begin
        if (RST) begin
            state_q    <= IDLE;
            dly_q      <= 5'd0;
            gap_q      <= 8'd0;
            stim_dly_q <= 5'd0;
            lct_q      <= 4'd0;
            l1a_q      <= 5'd0;
            rep_q      <= 8'd0;
            gap_len_q  <= 8'd0;
            seq_q      <= 8'd0;
            typ_q      <= 3'd0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            gap_q      <= gap_d;
            stim_dly_q <= stim_dly_d;
            lct_q      <= lct_d;
            l1a_q      <= l1a_d;
            rep_q      <= rep_d;
            gap_len_q  <= gap_len_d;
            seq_q      <= seq_d;
            typ_q      <= typ_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        dly_d      = dly_q;
        gap_d      = gap_q;
        stim_dly_d = stim_dly_q;
        lct_d      = lct_q;
        l1a_d      = l1a_q;
        rep_d      = rep_q;
        gap_len_d  = gap_len_q;
        seq_d      = seq_q;
        typ_d      = typ_q;
        done_d     = 1'b0;
        ovr_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_any && !bus.ABORT) begin
                    state_d   = STIM_WAIT;
                    lct_d     = bus.LCT_DLY;
                    l1a_d     = bus.L1A_DLY;
                    rep_d     = bus.BURST_LEN;
                    gap_len_d = SIM ? 8'd3 : bus.BURST_GAP;
                    seq_d     = 8'd0;
                    if (bus.CMD_INJ) begin
                        typ_d      = 3'b001;
                        stim_dly_d = bus.INJ_DLY;
                    end else if (bus.CMD_PLS) begin
                        typ_d      = 3'b010;
                        stim_dly_d = bus.EXT_DLY;
                    end else begin
                        typ_d      = 3'b100;
                        stim_dly_d = 5'd0;
                    end
                    dly_d = stim_dly_d;
                end
            end
            STIM_WAIT: begin
                if (dly_zero) begin
                    state_d = LCT_WAIT;
                    dly_d   = {1'b0, lct_q};
                end else begin
                    dly_d = dly_q - 5'd1;
                end
            end
            LCT_WAIT: begin
                if (dly_zero) begin
                    state_d = L1A_WAIT;
                    dly_d   = l1a_q;
                end else begin
                    dly_d = dly_q - 5'd1;
                end
            end
            L1A_WAIT: begin
                if (dly_zero) begin
                    seq_d = seq_q + 8'd1;
                    if (rep_q != 8'd0) begin
                        state_d = GAP;
                        rep_d   = rep_q - 8'd1;
                        gap_d   = gap_len_q;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    dly_d = dly_q - 5'd1;
                end
            end
            GAP: begin
                if (gap_q == 8'd0) begin
                    state_d = STIM_WAIT;
                    dly_d   = stim_dly_q;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A strobe arriving mid-burst is dropped and flagged. ABORT cancels the pending DONE.
        if (state_q != IDLE) begin
            ovr_d = cmd_any;
            if (bus.ABORT) begin
                state_d = IDLE;
                done_d  = 1'b0;
            end
        end
    end

    // Output decode. Outputs are forced low for as long as reset is held.
    always_comb begin
        busy      = 1'b0;
        stim_fire = 1'b0;
        lct_fire  = 1'b0;
        gtrg_fire = 1'b0;
        if (!RST) begin
            busy      = (state_q != IDLE);
            stim_fire = (state_q == STIM_WAIT) && dly_zero;
            lct_fire  = (state_q == LCT_WAIT) && dly_zero;
            gtrg_fire = (state_q == L1A_WAIT) && dly_zero;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_stim
            assign stim_vec[gi] = stim_fire & typ_q[gi];
        end
    endgenerate

    assign bus.INJECT   = stim_vec[0];
    assign bus.PULSE    = stim_vec[1];
    assign bus.PEDESTAL = stim_vec[2];
    assign bus.CAL_LCT  = lct_fire;
    assign bus.CAL_GTRG = gtrg_fire;
    assign bus.BUSY     = busy;
    assign bus.DONE     = done_q & ~RST;
    assign bus.OVERRUN  = ovr_q & ~RST;
    assign bus.SEQ_CNT  = RST ? 8'd0 : seq_q;

endmodule

// File: tb/tb_cal_trg_seq.sv
// Scoreboard bench for cal_trg_seq. Each scenario pushes the pulses it expects, tagged by cycle.
// A monitor pops one entry for every pulse the DUT produces.
module tb_cal_trg_seq;

    localparam int K_INJ  = 0;
    localparam int K_PLS  = 1;
    localparam int K_PED  = 2;
    localparam int K_LCT  = 3;
    localparam int K_GTRG = 4;
    localparam int K_DONE = 5;
    localparam int K_OVR  = 6;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc_abs = 0;
    int   base = 0;
    int   exp_v;
    int   exp_q[$];
    logic [6:0] obs;

    cal_trg_seq_if bus();

    cal_trg_seq #(.SIM(1'b0)) dut (
        .CLKCMS (clk),
        .RST    (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic string kname(input int k);
        case (k)
            K_INJ:   return "INJECT";
            K_PLS:   return "PULSE";
            K_PED:   return "PEDESTAL";
            K_LCT:   return "CAL_LCT";
            K_GTRG:  return "CAL_GTRG";
            K_DONE:  return "DONE";
            default: return "OVERRUN";
        endcase
    endfunction

    // Monitor: sample 1 time unit after each edge and match each pulse against the scoreboard.
    always @(posedge clk) begin
        #1;
        cyc_abs = cyc_abs + 1;
        obs = {bus.OVERRUN, bus.DONE, bus.CAL_GTRG, bus.CAL_LCT, bus.PEDESTAL, bus.PULSE, bus.INJECT};
        if (obs[4:0] != 5'b0) begin
            checks++;
            if ($countones(obs[4:0]) > 1) begin
                errors++;
                $display("FAIL exclusive: cyc=%0d got stim=%b required one-hot", cyc_abs - base, obs[4:0]);
            end
        end
        for (int k = 0; k < 7; k++) begin
            if (obs[k] === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected: %s at cyc=%0d, required none", kname(k), cyc_abs - base);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (exp_v != cyc_abs * 8 + k) begin
                        errors++;
                        $display("FAIL event: got %s at cyc=%0d, required %s at cyc=%0d",
                                 kname(k), cyc_abs - base, kname(exp_v % 8), exp_v / 8 - base);
                    end else begin
                        $display("event %s at cyc=%0d ok", kname(k), cyc_abs - base);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int rel, input int kind);
        exp_q.push_back((base + rel) * 8 + kind);
    endtask

    task automatic set_cfg(input logic [4:0] inj, input logic [4:0] ext, input logic [3:0] lct,
                           input logic [4:0] l1a, input logic [7:0] blen, input logic [7:0] bgap);
        bus.INJ_DLY   = inj;
        bus.EXT_DLY   = ext;
        bus.LCT_DLY   = lct;
        bus.L1A_DLY   = l1a;
        bus.BURST_LEN = blen;
        bus.BURST_GAP = bgap;
    endtask

    task automatic drain(input string name);
        repeat (4) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d outstanding events required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.CMD_INJ = 1'b1;
        repeat (3) tick();
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0000000", obs);
        end
        checks++;
        if (bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b required 0", bus.BUSY);
        end
        checks++;
        if (bus.SEQ_CNT !== 8'd0) begin
            errors++;
            $display("FAIL reset_seq: got %0d required 0", bus.SEQ_CNT);
        end
        rst = 1'b0;
        bus.CMD_INJ = 1'b0;
        tick();
        checks++;
        if (bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_ignore_cmd: busy got %b required 0", bus.BUSY);
        end
        drain("reset");
    endtask

    task automatic test_inject();
        set_cfg(5'd15, 5'd0, 4'd8, 5'd11, 8'd0, 8'd0);
        base = cyc_abs;
        push(16, K_INJ); push(25, K_LCT); push(37, K_GTRG); push(38, K_DONE);
        bus.CMD_INJ = 1'b1;
        tick();
        bus.CMD_INJ = 1'b0;
        checks++;
        if (bus.BUSY !== 1'b1) begin
            errors++;
            $display("FAIL inject_busy: got %b required 1", bus.BUSY);
        end
        repeat (37) tick();
        checks++;
        if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b1) begin
            errors++;
            $display("FAIL inject_end: got busy=%b done=%b required busy=0 done=1", bus.BUSY, bus.DONE);
        end
        checks++;
        if (bus.SEQ_CNT !== 8'd1) begin
            errors++;
            $display("FAIL inject_seq: got %0d required 1", bus.SEQ_CNT);
        end
        drain("inject");
    endtask

    task automatic test_ped_burst();
        set_cfg(5'd0, 5'd0, 4'd0, 5'd0, 8'd2, 8'd3);
        base = cyc_abs;
        push(1, K_PED);  push(2, K_LCT);  push(3, K_GTRG);
        push(8, K_PED);  push(9, K_LCT);  push(10, K_GTRG);
        push(15, K_PED); push(16, K_LCT); push(17, K_GTRG); push(18, K_DONE);
        bus.CMD_PED = 1'b1;
        tick();
        bus.CMD_PED = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus.SEQ_CNT !== 8'd1 || bus.BUSY !== 1'b1) begin
            errors++;
            $display("FAIL burst_gap: got seq=%0d busy=%b required seq=1 busy=1", bus.SEQ_CNT, bus.BUSY);
        end
        repeat (14) tick();
        checks++;
        if (bus.SEQ_CNT !== 8'd3 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL burst_end: got seq=%0d busy=%b required seq=3 busy=0", bus.SEQ_CNT, bus.BUSY);
        end
        drain("burst");
    endtask

    task automatic test_priority_drop();
        set_cfg(5'd15, 5'd7, 4'd8, 5'd11, 8'd0, 8'd0);
        base = cyc_abs;
        push(6, K_OVR); push(16, K_INJ); push(25, K_LCT); push(37, K_GTRG); push(38, K_DONE);
        bus.CMD_INJ = 1'b1;
        bus.CMD_PLS = 1'b1;
        tick();
        bus.CMD_INJ = 1'b0;
        bus.CMD_PLS = 1'b0;
        repeat (4) tick();
        bus.CMD_PLS = 1'b1;
        tick();
        bus.CMD_PLS = 1'b0;
        checks++;
        if (bus.OVERRUN !== 1'b1) begin
            errors++;
            $display("FAIL drop_overrun: got %b required 1", bus.OVERRUN);
        end
        repeat (32) tick();
        checks++;
        if (bus.DONE !== 1'b1 || bus.SEQ_CNT !== 8'd1) begin
            errors++;
            $display("FAIL drop_end: got done=%b seq=%0d required done=1 seq=1", bus.DONE, bus.SEQ_CNT);
        end
        drain("priority");
    endtask

    task automatic test_abort();
        set_cfg(5'd0, 5'd2, 4'd3, 5'd5, 8'd4, 8'd3);
        base = cyc_abs;
        push(3, K_PLS); push(7, K_LCT);
        bus.CMD_PLS = 1'b1;
        tick();
        bus.CMD_PLS = 1'b0;
        repeat (7) tick();
        bus.ABORT = 1'b1;
        tick();
        bus.ABORT = 1'b0;
        checks++;
        if (bus.BUSY !== 1'b0 || bus.SEQ_CNT !== 8'd0) begin
            errors++;
            $display("FAIL abort_state: got busy=%b seq=%0d required busy=0 seq=0", bus.BUSY, bus.SEQ_CNT);
        end
        repeat (30) tick();
        drain("abort");
        base = cyc_abs;
        bus.ABORT = 1'b1;
        bus.CMD_PED = 1'b1;
        tick();
        bus.ABORT = 1'b0;
        bus.CMD_PED = 1'b0;
        checks++;
        if (bus.BUSY !== 1'b0 || bus.OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle_cmd: got busy=%b ovr=%b required busy=0 ovr=0", bus.BUSY, bus.OVERRUN);
        end
        drain("abort_idle");
    endtask

    task automatic test_reset_mid();
        set_cfg(5'd0, 5'd13, 4'd0, 5'd0, 8'd2, 8'd10);
        base = cyc_abs;
        push(1, K_PED); push(2, K_LCT); push(3, K_GTRG);
        bus.CMD_PED = 1'b1;
        tick();
        bus.CMD_PED = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (obs !== 7'b0 || bus.BUSY !== 1'b0 || bus.SEQ_CNT !== 8'd0) begin
            errors++;
            $display("FAIL rstmid_clear: got obs=%b busy=%b seq=%0d required all 0", obs, bus.BUSY, bus.SEQ_CNT);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_idle: got busy=%b required 0", bus.BUSY);
        end
        set_cfg(5'd0, 5'd13, 4'd0, 5'd0, 8'd0, 8'd0);
        base = cyc_abs;
        push(14, K_PLS); push(15, K_LCT); push(16, K_GTRG); push(17, K_DONE);
        bus.CMD_PLS = 1'b1;
        tick();
        bus.CMD_PLS = 1'b0;
        repeat (16) tick();
        checks++;
        if (bus.DONE !== 1'b1 || bus.SEQ_CNT !== 8'd1) begin
            errors++;
            $display("FAIL rstmid_resume: got done=%b seq=%0d required done=1 seq=1", bus.DONE, bus.SEQ_CNT);
        end
        drain("reset_mid");
    endtask

    task automatic test_latched();
        set_cfg(5'd15, 5'd0, 4'd0, 5'd0, 8'd2, 8'd3);
        base = cyc_abs;
        push(16, K_INJ); push(17, K_LCT); push(18, K_GTRG);
        push(38, K_INJ); push(39, K_LCT); push(40, K_GTRG);
        push(60, K_INJ); push(61, K_LCT); push(62, K_GTRG); push(63, K_DONE);
        bus.CMD_INJ = 1'b1;
        tick();
        bus.CMD_INJ = 1'b0;
        repeat (4) tick();
        set_cfg(5'd3, 5'd0, 4'd5, 5'd9, 8'd0, 8'd0);
        repeat (58) tick();
        checks++;
        if (bus.DONE !== 1'b1 || bus.SEQ_CNT !== 8'd3) begin
            errors++;
            $display("FAIL latched_end: got done=%b seq=%0d required done=1 seq=3", bus.DONE, bus.SEQ_CNT);
        end
        drain("latched");
    endtask

    task automatic test_back_to_back();
        set_cfg(5'd0, 5'd31, 4'd0, 5'd0, 8'd0, 8'd0);
        base = cyc_abs;
        push(32, K_PLS); push(33, K_LCT); push(34, K_GTRG); push(35, K_DONE);
        push(36, K_PED); push(37, K_LCT); push(38, K_GTRG); push(39, K_DONE);
        bus.CMD_PLS = 1'b1;
        tick();
        bus.CMD_PLS = 1'b0;
        repeat (34) tick();
        checks++;
        if (bus.DONE !== 1'b1 || bus.SEQ_CNT !== 8'd1) begin
            errors++;
            $display("FAIL b2b_first: got done=%b seq=%0d required done=1 seq=1", bus.DONE, bus.SEQ_CNT);
        end
        bus.CMD_PED = 1'b1;
        tick();
        bus.CMD_PED = 1'b0;
        checks++;
        if (bus.SEQ_CNT !== 8'd0 || bus.BUSY !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got seq=%0d busy=%b required seq=0 busy=1", bus.SEQ_CNT, bus.BUSY);
        end
        repeat (3) tick();
        checks++;
        if (bus.DONE !== 1'b1 || bus.SEQ_CNT !== 8'd1) begin
            errors++;
            $display("FAIL b2b_second: got done=%b seq=%0d required done=1 seq=1", bus.DONE, bus.SEQ_CNT);
        end
        drain("back_to_back");
    endtask

    initial begin
        rst = 1'b1;
        bus.CMD_INJ = 1'b0;
        bus.CMD_PLS = 1'b0;
        bus.CMD_PED = 1'b0;
        bus.ABORT   = 1'b0;
        set_cfg(5'd0, 5'd0, 4'd0, 5'd0, 8'd0, 8'd0);
        #1;
        test_reset();
        test_inject();
        test_ped_burst();
        test_priority_drop();
        test_abort();
        test_reset_mid();
        test_latched();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cal_trg_seq.md
CAL_TRG_SEQ -- requirements
Module: cal_trg_seq

Interface
REQ-001 Parameter SIM, default 0, meaning: 1 forces the burst gap to 4 cycles to shorten simulation; 0 uses BURST_GAP.
REQ-002 Clocking: one clock, CLKCMS. Reset: RST, synchronous, active-high.
REQ-003 CLKCMS  in  1  40 MHz CMS clock; all logic on the rising edge.
REQ-004 RST  in  1  synchronous active-high reset.
REQ-005 CMD_INJ, CMD_PLS, CMD_PED  in  1 each  one-cycle command strobes (CCB or JTAG).
REQ-006 ABORT  in  1  one-cycle strobe; terminates any sequence.
REQ-007 INJ_DLY  in  5  cycles from command to INJECT.
REQ-008 EXT_DLY  in  5  cycles from command to PULSE.
REQ-009 LCT_DLY  in  4  cycles from stimulus to CAL_LCT.
REQ-010 L1A_DLY  in  5  cycles from CAL_LCT to CAL_GTRG.
REQ-011 BURST_LEN  in  8  extra repetitions; 0 means a single sequence.
REQ-012 BURST_GAP  in  8  idle cycles between repetitions.
REQ-013 Stimulus outputs, each out 1, one-cycle pulses: INJECT, PULSE, PEDESTAL, CAL_LCT, CAL_GTRG.
REQ-014 BUSY  out  1  high whenever the FSM is not in IDLE.
REQ-015 DONE  out  1  one-cycle pulse at burst completion.
REQ-016 OVERRUN  out  1  one-cycle pulse when a command is dropped.
REQ-017 SEQ_CNT  out  8  sequences completed in the current burst.

Function
REQ-018 FSM states: IDLE, STIM_WAIT, LCT_WAIT, L1A_WAIT, GAP.
REQ-019 Command acceptance in IDLE: a strobe sampled on edge t latches command type, all delays and BURST_LEN; the FSM enters STIM_WAIT.
REQ-020 Simultaneous command strobes: priority CMD_INJ > CMD_PLS > CMD_PED; the lower-priority strobes are discarded without OVERRUN.
REQ-021 Stimulus timing: the stimulus pulse is asserted in cycle t+1+d.
- d = INJ_DLY for INJECT, EXT_DLY for PULSE, 0 for PEDESTAL.
- d = 0 gives the stimulus one cycle after the command.
REQ-022 CAL_LCT is asserted LCT_DLY+1 cycles after the stimulus cycle (LCT_WAIT).
REQ-023 CAL_GTRG is asserted L1A_DLY+1 cycles after the CAL_LCT cycle (L1A_WAIT).
REQ-024 On each CAL_GTRG cycle, SEQ_CNT increments on the following edge; it wraps 255 to 0.
REQ-025 After CAL_GTRG with repetitions remaining, the FSM enters GAP.
- GAP lasts BURST_GAP+1 cycles (4 if SIM=1).
- It then re-enters STIM_WAIT with the latched type and delays; no new command is needed.
REQ-026 After the final CAL_GTRG (BURST_LEN+1 sequences total), DONE pulses in the next cycle and the FSM returns to IDLE in that same cycle.
REQ-027 Latched values: changes to the delay, BURST_LEN or BURST_GAP inputs during a burst have no effect until the next accepted command.
REQ-028 Commands while BUSY are dropped: the burst is unaffected and OVERRUN pulses the next cycle (one pulse per dropped strobe cycle).
REQ-029 ABORT in any non-IDLE state: the next state is IDLE, no further stimulus, and DONE is not asserted.
REQ-030 ABORT coincident with a command in IDLE: ABORT wins, the command is discarded, and OVERRUN is not asserted.
REQ-031 SEQ_CNT clears to 0 on command acceptance and holds its value after DONE or ABORT.
REQ-032 Exclusivity: at most one of INJECT, PULSE, PEDESTAL, CAL_LCT, CAL_GTRG is high in any cycle.
REQ-033 Delay counters are 5-bit down-counters with no underflow; a maximum delay of 31 yields 32 cycles.

Reset
REQ-034 While RST is high, the FSM is in IDLE and all outputs and SEQ_CNT are 0; commands are ignored.
REQ-035 RST mid-burst: the burst terminates on the same edge with no DONE; operation resumes on the first command after RST falls.

Verification
REQ-036 Injection timing: INJ_DLY=15, LCT_DLY=8, L1A_DLY=11, BURST_LEN=0, CMD_INJ at cycle 0 -> INJECT at 16, CAL_LCT at 25, CAL_GTRG at 37, DONE at 38, SEQ_CNT=1.
REQ-037 Pedestal burst: CMD_PED, LCT_DLY=0, L1A_DLY=0, BURST_LEN=2, BURST_GAP=3 -> PEDESTAL at 1, 8, 15; CAL_GTRG at 3, 10, 17; DONE at 18; SEQ_CNT=3.
REQ-038 Priority and drop: CMD_INJ and CMD_PLS together at cycle 0 -> INJECT only; CMD_PLS at cycle 5 while BUSY -> OVERRUN at 6, sequence timing unchanged.
REQ-039 Abort: ABORT in the cycle after CAL_LCT of the first sequence with BURST_LEN=4 -> no CAL_GTRG, BUSY low next cycle, DONE never asserted, SEQ_CNT=0.
REQ-040 Reset mid-burst: RST during GAP -> all outputs 0 next cycle; a new CMD_PLS with EXT_DLY=13 -> PULSE 14 cycles later.
REQ-041 Latched delays: change INJ_DLY from 15 to 3 mid-burst -> all repetitions keep the 16-cycle stimulus delay.
